// File: rtl/reg_req_encoder.sv
// Round-robin request encoder: captures request lines into a pending set and
// offers one register index at a time, holding each offer until acknowledged.
module reg_req_encoder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Req,
    input  logic        Ld,
    input  logic        Ack,
    output logic [3:0]  Code,
    output logic        Valid,
    output logic [4:0]  Count,
    output logic        Dup
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t      state_r;
    logic [15:0] pending_r;
    logic [3:0]  ptr_r;
    logic [3:0]  code_r;
    logic        valid_r;
    logic        dup_r;

    logic [15:0] clear_s;
    logic [15:0] load_s;
    logic [15:0] pending_next_s;
    logic        dup_hit_s;
    logic [3:0]  pick_s;

    // First set bit at or above ptr, wrapping 15 -> 0; zero when nothing is set.
    function automatic logic [3:0] rr_pick(input logic [15:0] pend, input logic [3:0] ptr);
        logic [3:0] idx;
        logic       found;
        rr_pick = 4'd0;
        found   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!found && pend[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

    function automatic logic [4:0] count_ones(input logic [15:0] pend);
        count_ones = 5'd0;
        for (int i = 0; i < 16; i++) begin
            count_ones = count_ones + {4'd0, pend[i]};
        end
    endfunction

    // Next pending set: a grant clears its bit first, so a same-edge request re-arms it.
    always_comb begin
        clear_s = 16'h0000;
        if ((state_r == OFFER) && Ack) begin
            clear_s = 16'h0001 << code_r;
        end else begin
            clear_s = 16'h0000;
        end
        load_s         = Ld ? Req : 16'h0000;
        pending_next_s = (pending_r & ~clear_s) | load_s;
        dup_hit_s      = |(load_s & pending_r & ~clear_s);
        pick_s         = rr_pick(pending_r, ptr_r);
    end

    // Offer FSM together with the pending set, pointer and sticky duplicate flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r   <= IDLE;
            pending_r <= 16'h0000;
            ptr_r     <= 4'd0;
            code_r    <= 4'd0;
            valid_r   <= 1'b0;
            dup_r     <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            if (dup_hit_s) begin
                dup_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (|pending_r) begin
                        state_r <= OFFER;
                        code_r  <= pick_s;
                        valid_r <= 1'b1;
                    end
                end
                OFFER: begin
                    if (Ack) begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                        ptr_r   <= code_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign Code  = code_r;
    assign Valid = valid_r;
    assign Dup   = dup_r;
    assign Count = count_ones(pending_r);

endmodule
